// File: rtl/spi_master.sv
// Memory-mapped SPI master: TX FIFO, RX holding register and a shift FSM for SPI modes 0-3.
// Define SPI_MASTER_IRQ_EN to build the interrupt output; without it, irq is tied low.
module spi_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        spi_req,
  input  logic        spi_sel,
  input  logic        spi_write,
  input  logic [1:0]  spi_reg,
  input  logic [31:0] spi_wdata,
  output logic        spi_gnt,
  output logic        spi_rvalid,
  output logic [31:0] spi_rdata,
  input  logic        MISO,
  output logic        SCK,
  output logic        MOSI,
  output logic        SSn,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] ctrl_div;
  logic             ctrl_cpol, ctrl_cpha, ctrl_ss, ctrl_ie;

  logic [7:0]       fifo [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic [7:0]       rx_byte;
  logic             rx_valid, rx_overrun, tx_drop;

  logic [DIV_W-1:0] div_q, cnt;
  logic             cpha_q;
  logic [3:0]       half;
  logic [7:0]       tx_sh, rx_sh;

  logic             acc, wr_acc, rd_acc;
  logic             full, empty, busy;
  logic             pop, push_req, push;
  logic             rx_rd, stat_rd;
  logic [31:0]      ctrl_rd, status_rd, rd_data;
  logic             unused_wdata;

  assign acc      = spi_req & spi_sel;
  assign spi_gnt  = acc;
  assign wr_acc   = acc & spi_write;
  assign rd_acc   = acc & ~spi_write;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE) || !empty;
  assign pop      = (state == LOAD);
  assign push_req = wr_acc && (spi_reg == 2'd2);
  // A same-cycle pop frees the slot the push lands in, so a full FIFO still accepts it.
  assign push     = push_req && (!full || pop);
  assign rx_rd    = rd_acc && (spi_reg == 2'd3);
  assign stat_rd  = rd_acc && (spi_reg == 2'd1);

  assign SSn      = ~ctrl_ss;
  assign unused_wdata = &{1'b0, spi_wdata[31:12]};

  assign ctrl_rd   = {20'b0, ctrl_ie, ctrl_ss, ctrl_cpha, ctrl_cpol, 8'(ctrl_div)};
  assign status_rd = {20'b0, 4'(count), 2'b0, tx_drop, rx_overrun, rx_valid, empty, full, busy};

  always_comb begin
    rd_data = '0;
    case (spi_reg)
      2'd0:    rd_data = ctrl_rd;
      2'd1:    rd_data = status_rd;
      2'd3:    rd_data = {24'b0, rx_byte};
      default: rd_data = '0;
    endcase
  end

  // Bus response, control register and status flags.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      spi_rvalid <= 1'b0;
      spi_rdata  <= '0;
      ctrl_div   <= '0;
      ctrl_cpol  <= 1'b0;
      ctrl_cpha  <= 1'b0;
      ctrl_ss    <= 1'b0;
      ctrl_ie    <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      spi_rvalid <= acc;
      spi_rdata  <= rd_acc ? rd_data : '0;
      if (wr_acc && spi_reg == 2'd0) begin
        ctrl_div  <= spi_wdata[DIV_W-1:0];
        ctrl_cpol <= spi_wdata[8];
        ctrl_cpha <= spi_wdata[9];
        ctrl_ss   <= spi_wdata[10];
        ctrl_ie   <= spi_wdata[11];
      end
      if (stat_rd) begin
        rx_overrun <= 1'b0;
        tx_drop    <= 1'b0;
      end
      if (push_req && !push) tx_drop <= 1'b1;
      if (state == DONE) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_rd) rx_overrun <= 1'b1;
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= spi_wdata[7:0];
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Shift engine: even half-period index ends on the leading SCK edge, odd on the trailing edge.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= IDLE;
      SCK    <= 1'b0;
      MOSI   <= 1'b0;
      div_q  <= '0;
      cnt    <= '0;
      cpha_q <= 1'b0;
      half   <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
    end else begin
      case (state)
        IDLE: begin
          SCK <= ctrl_cpol;
          if (!empty) state <= LOAD;
        end
        LOAD: begin
          div_q  <= ctrl_div;
          cpha_q <= ctrl_cpha;
          SCK    <= ctrl_cpol;
          cnt    <= '0;
          half   <= '0;
          tx_sh  <= fifo[rd_ptr];
          MOSI   <= ctrl_cpha ? 1'b0 : fifo[rd_ptr][7];
          state  <= XFER;
        end
        XFER: begin
          if (cnt == div_q) begin
            cnt  <= '0;
            SCK  <= ~SCK;
            half <= half + 4'd1;
            if (half[0] == cpha_q) begin
              rx_sh <= {rx_sh[6:0], MISO};
            end else begin
              MOSI  <= cpha_q ? tx_sh[7] : tx_sh[6];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (half == 4'd15) state <= DONE;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DONE: state <= empty ? IDLE : LOAD;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  logic xfer_seen;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      xfer_seen <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (state == DONE) xfer_seen <= 1'b1;
      irq <= ctrl_ie && (rx_valid || (empty && state == IDLE && xfer_seen));
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
